// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and a
// lowest-set-bit helper used to pick the next channel to release.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_STRETCH = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seqState_t;

  function automatic logic [15:0] lowestSet(input logic [15:0] v);
    return v & (~v + 16'd1);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Reset synchroniser: asserts asynchronously, releases after STAGES rising edges.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstN,
  output logic syncRstN
);

  logic [STAGES-1:0] chainR;

  // Shift a constant one through the chain once the raw reset lifts
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      chainR <= '0;
    end else begin
      chainR <= {chainR[STAGES-2:0], 1'b1};
    end
  end

  assign syncRstN = chainR[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: synchronise, stretch, then release channels in
// ascending order with a fixed stagger. RSTSEQ_WATCHDOG_EN adds the RUN-cycle watchdog.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    Clock,
  input  logic                    PowerOnReset,
  input  logic                    SoftResetReq,
  input  logic [NUM_CHANNELS-1:0] ChannelMask,
  output logic [NUM_CHANNELS-1:0] ChannelResetN,
  output logic                    AllReleased,
  output logic                    Busy,
  output logic [CNT_WIDTH-1:0]    CycleCount,
  output logic                    Timeout
);

  localparam logic [CNT_WIDTH-1:0] STRETCH_LAST = CNT_WIDTH'(STRETCH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGGER_LAST =
    CNT_WIDTH'((STAGGER_CYCLES == 0) ? 0 : STAGGER_CYCLES - 1);

  logic                    syncRstN;
  seqState_t               stateR, stateS;
  logic [CNT_WIDTH-1:0]    stretchCntR, stretchCntS, staggerCntR, staggerCntS;
  logic [NUM_CHANNELS-1:0] pendingR, pendingS, chanR, chanS;
  logic [NUM_CHANNELS-1:0] firstBitS, nextBitS;

  reset_sync #(.STAGES(SYNC_STAGES)) uSync (
    .clk      (Clock),
    .rstN     (PowerOnReset),
    .syncRstN (syncRstN)
  );

  assign firstBitS = NUM_CHANNELS'(lowestSet(16'(ChannelMask)));
  assign nextBitS  = NUM_CHANNELS'(lowestSet(16'(pendingR)));

  // Next-state: pendingR holds the latched mask minus channels already released
  always_comb begin
    stateS      = stateR;
    stretchCntS = stretchCntR;
    staggerCntS = staggerCntR;
    pendingS    = pendingR;
    chanS       = chanR;
    if (SoftResetReq) begin
      stateS      = ST_STRETCH;
      stretchCntS = '0;
      staggerCntS = '0;
      pendingS    = '0;
      chanS       = '0;
    end else begin
      case (stateR)
        ST_STRETCH: begin
          if (stretchCntR == STRETCH_LAST) begin
            stateS      = ST_RELEASE;
            stretchCntS = '0;
            staggerCntS = '0;
            // First release lands on the same edge that enters RELEASE
            if (STAGGER_CYCLES == 0) begin
              chanS    = ChannelMask;
              pendingS = '0;
            end else begin
              chanS    = firstBitS;
              pendingS = ChannelMask & ~firstBitS;
            end
          end else begin
            stretchCntS = stretchCntR + CNT_WIDTH'(1);
          end
        end
        ST_RELEASE: begin
          if (pendingR == '0) begin
            stateS = ST_RUN;
          end else if (staggerCntR == STAGGER_LAST) begin
            chanS       = chanR | nextBitS;
            pendingS    = pendingR & ~nextBitS;
            staggerCntS = '0;
          end else begin
            staggerCntS = staggerCntR + CNT_WIDTH'(1);
          end
        end
        ST_RUN: begin
          stateS = ST_RUN;
        end
        default: begin
          stateS = ST_STRETCH;
        end
      endcase
    end
  end

  // Sequencer state, counters and channel reset registers
  always_ff @(posedge Clock or negedge syncRstN) begin
    if (!syncRstN) begin
      stateR      <= ST_STRETCH;
      stretchCntR <= '0;
      staggerCntR <= '0;
      pendingR    <= '0;
      chanR       <= '0;
    end else begin
      stateR      <= stateS;
      stretchCntR <= stretchCntS;
      staggerCntR <= staggerCntS;
      pendingR    <= pendingS;
      chanR       <= chanS;
    end
  end

  assign ChannelResetN = chanR;
  assign AllReleased   = (stateR == ST_RUN);
  // Qualified by syncRstN so Busy drops with the asynchronous reset assertion
  assign Busy          = syncRstN & (stateR != ST_RUN);

`ifdef RSTSEQ_WATCHDOG_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] cycleCntR, cycleCntS;
  logic                 timeoutR, timeoutS;

  // Saturating RUN-cycle counter; Timeout is raised together with the matching count
  always_comb begin
    cycleCntS = cycleCntR;
    timeoutS  = timeoutR;
    if (SoftResetReq) begin
      cycleCntS = '0;
      timeoutS  = 1'b0;
    end else if ((stateR == ST_RUN) && (cycleCntR != {CNT_WIDTH{1'b1}})) begin
      cycleCntS = cycleCntR + CNT_WIDTH'(1);
      if (cycleCntS == TIMEOUT_VAL) begin
        timeoutS = 1'b1;
      end else begin
        timeoutS = timeoutR;
      end
    end else begin
      cycleCntS = cycleCntR;
    end
  end

  // Watchdog registers
  always_ff @(posedge Clock or negedge syncRstN) begin
    if (!syncRstN) begin
      cycleCntR <= '0;
      timeoutR  <= 1'b0;
    end else begin
      cycleCntR <= cycleCntS;
      timeoutR  <= timeoutS;
    end
  end

  assign CycleCount = cycleCntR;
  assign Timeout    = timeoutR;
`else
  assign CycleCount = '0;
  assign Timeout    = 1'b0;
`endif

endmodule
